// File: rtl/lcb_responder.sv
// lcb_responder: RS485 request/response slave.
// Receives a 4-byte request (A5, CYC, CNT, CHK). If the request is valid it
// drives the bus and answers with 5A, CYC, CNT bytes read from data RAM at
// CYC*32+i, and an XOR checksum. Rejected or timed-out requests bump a
// saturating error counter.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   iRxData, iRxValid   received byte + one-cycle strobe
//   oRdAddr, oRdEn      RAM read port; iRdData valid one cycle after oRdEn
//   iRdData             RAM read data
//   oTxData, oTxStart   byte + start strobe to the UART transmitter
//   iTxReady            transmitter idle
//   oDirTX, oDirRX      RS485 driver enable / receiver disable
//   oBusy               FSM not in IDLE
//   oErrCnt             saturating rejected-request count
module lcb_responder #(
    parameter int TIMEOUT = 800,
    parameter int GUARD   = 80,
    parameter int MAXCNT  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  iRxData,
    input  logic        iRxValid,
    output logic [10:0] oRdAddr,
    output logic        oRdEn,
    input  logic [7:0]  iRdData,
    output logic [7:0]  oTxData,
    output logic        oTxStart,
    input  logic        iTxReady,
    output logic        oDirTX,
    output logic        oDirRX,
    output logic        oBusy,
    output logic [7:0]  oErrCnt
);

    localparam int TW = $clog2(TIMEOUT + GUARD + 2);
    localparam logic [TW-1:0] TMO  = TW'(TIMEOUT);
    localparam logic [TW-1:0] GEND = TW'(GUARD - 1);

    typedef enum logic [3:0] {
        IDLE, RX_CYC, RX_CNT, RX_CHK, GUARD_ON, TX_HDR, TX_CYC,
        FETCH, TX_DATA, TX_CHK, GUARD_OFF
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    cyc_q, cyc_d, cnt_q, cnt_d, idx_q, idx_d;
    logic [7:0]    acc_q, acc_d, rd_q, rd_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          armed_q, armed_d, sent_q, sent_d;
    logic [7:0]    tx_data_d, err_d;
    logic [10:0]   rd_addr_d;
    logic          tx_start_d, rd_en_d, dir_tx_d, dir_rx_d, busy_d;
    logic          err_inc, tx_go, chk_ok;
    logic [7:0]    cyc6;

    assign cyc6   = {2'b00, cyc_q[5:0]};
    // Request checksum covers the raw CYC byte, including its ignored top bits.
    assign chk_ok = (iRxData == (8'hA5 ^ cyc_q ^ cnt_q)) &&
                    (cnt_q != 8'd0) && (cnt_q <= 8'(MAXCNT));
    // armed: transmitter has been seen busy since our last strobe, so a
    // high iTxReady now really means the previous byte is gone.
    assign tx_go  = iTxReady & armed_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cyc_q    <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            acc_q    <= '0;
            rd_q     <= '0;
            timer_q  <= '0;
            armed_q  <= 1'b1;
            sent_q   <= 1'b0;
            oTxData  <= '0;
            oTxStart <= 1'b0;
            oRdAddr  <= '0;
            oRdEn    <= 1'b0;
            oDirTX   <= 1'b0;
            oDirRX   <= 1'b0;
            oBusy    <= 1'b0;
            oErrCnt  <= '0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            rd_q     <= rd_d;
            timer_q  <= timer_d;
            armed_q  <= armed_d;
            sent_q   <= sent_d;
            oTxData  <= tx_data_d;
            oTxStart <= tx_start_d;
            oRdAddr  <= rd_addr_d;
            oRdEn    <= rd_en_d;
            oDirTX   <= dir_tx_d;
            oDirRX   <= dir_rx_d;
            oBusy    <= busy_d;
            oErrCnt  <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        rd_d       = rd_q;
        timer_d    = timer_q;
        armed_d    = armed_q | ~iTxReady;
        sent_d     = sent_q;
        tx_data_d  = oTxData;
        tx_start_d = 1'b0;
        rd_addr_d  = oRdAddr;
        rd_en_d    = 1'b0;
        dir_tx_d   = oDirTX;
        dir_rx_d   = oDirRX;
        err_inc    = 1'b0;

        case (state_q)
            IDLE: begin
                if (iRxValid && iRxData == 8'hA5) begin
                    state_d = RX_CYC;
                    timer_d = '0;
                end
            end
            RX_CYC, RX_CNT, RX_CHK: begin
                if (iRxValid) begin
                    timer_d = '0;
                    case (state_q)
                        RX_CYC: begin
                            cyc_d   = iRxData;
                            state_d = RX_CNT;
                        end
                        RX_CNT: begin
                            cnt_d   = iRxData;
                            state_d = RX_CHK;
                        end
                        default: begin
                            if (chk_ok) begin
                                state_d  = GUARD_ON;
                                dir_tx_d = 1'b1;
                                dir_rx_d = 1'b1;
                            end else begin
                                state_d = IDLE;
                                err_inc = 1'b1;
                            end
                        end
                    endcase
                end else if (timer_q == TMO) begin
                    state_d = IDLE;
                    err_inc = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            GUARD_ON: begin
                if (timer_q == GEND) state_d = TX_HDR;
                else                 timer_d = timer_q + TW'(1);
            end
            TX_HDR: begin
                if (tx_go) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = 8'h5A;
                    acc_d      = 8'h5A;
                    armed_d    = 1'b0;
                    state_d    = TX_CYC;
                end
            end
            TX_CYC: begin
                if (tx_go) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = cyc6;
                    acc_d      = acc_q ^ cyc6;
                    armed_d    = 1'b0;
                    idx_d      = '0;
                    timer_d    = '0;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                // timer sequences the read: issue, wait, capture.
                if (timer_q == TW'(0)) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = {cyc_q[5:0], 5'b00000} + 11'(idx_q);
                    timer_d   = TW'(1);
                end else if (timer_q == TW'(1)) begin
                    timer_d = TW'(2);
                end else begin
                    rd_d    = iRdData;
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_go) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = rd_q;
                    acc_d      = acc_q ^ rd_q;
                    armed_d    = 1'b0;
                    idx_d      = idx_q + 8'd1;
                    timer_d    = '0;
                    if (idx_q + 8'd1 < cnt_q) begin
                        state_d = FETCH;
                    end else begin
                        state_d = TX_CHK;
                        sent_d  = 1'b0;
                    end
                end
            end
            TX_CHK: begin
                // First wait to send CHK, then wait for it to leave the line.
                if (!sent_q) begin
                    if (tx_go) begin
                        tx_start_d = 1'b1;
                        tx_data_d  = acc_q;
                        armed_d    = 1'b0;
                        sent_d     = 1'b1;
                    end
                end else if (tx_go) begin
                    state_d = GUARD_OFF;
                    timer_d = '0;
                end
            end
            GUARD_OFF: begin
                if (timer_q == GEND) begin
                    dir_tx_d = 1'b0;
                    dir_rx_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        err_d  = (err_inc && oErrCnt != 8'hFF) ? oErrCnt + 8'd1 : oErrCnt;
    end

endmodule

// File: tb/tb_lcb_responder.sv
// Scoreboard bench for lcb_responder: expected TX bytes and RAM read
// addresses are queued when a request is driven and checked as the DUT
// strobes them. Transmitter and RAM are modelled behaviourally.
module tb_lcb_responder;
    localparam int TIMEOUT = 800;
    localparam int GUARD   = 80;
    localparam int MAXCNT  = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  iRxData = '0;
    logic        iRxValid = 1'b0;
    logic [10:0] oRdAddr;
    logic        oRdEn;
    logic [7:0]  iRdData = '0;
    logic [7:0]  oTxData;
    logic        oTxStart;
    logic        iTxReady = 1'b1;
    logic        oDirTX, oDirRX, oBusy;
    logic [7:0]  oErrCnt;

    lcb_responder #(.TIMEOUT(TIMEOUT), .GUARD(GUARD), .MAXCNT(MAXCNT)) dut (
        .clk(clk), .rst(rst), .iRxData(iRxData), .iRxValid(iRxValid),
        .oRdAddr(oRdAddr), .oRdEn(oRdEn), .iRdData(iRdData),
        .oTxData(oTxData), .oTxStart(oTxStart), .iTxReady(iTxReady),
        .oDirTX(oDirTX), .oDirRX(oDirRX), .oBusy(oBusy), .oErrCnt(oErrCnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    logic [7:0]  ram [0:2047];
    logic [7:0]  txq [$];
    logic [10:0] addrq [$];
    int tx_len = 3, tx_cnt = 0;
    int nstrobe = 0, pre_cnt = 0, post_cnt = 0, dir_hits = 0;
    logic        rd_pend = 1'b0;
    logic [10:0] rd_paddr = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Monitor + transmitter + RAM models, all on the falling edge.
    always @(negedge clk) begin
        if (oDirTX) dir_hits++;
        if (oDirTX && nstrobe == 0 && !oTxStart) pre_cnt++;
        if (oDirTX && nstrobe > 0 && txq.size() == 0 && tx_cnt == 0 && iTxReady) post_cnt++;
        if (oTxStart) begin
            nstrobe++;
            chk("tx_ready", 32'(iTxReady), 1);
            if (txq.size() > 0) chk("tx_byte", 32'(oTxData), 32'(txq.pop_front()));
            else                chk("tx_spurious", 32'(oTxStart), 0);
            tx_cnt = tx_len;
        end else if (tx_cnt != 0) begin
            iTxReady = 1'b0;
            tx_cnt--;
        end else begin
            iTxReady = 1'b1;
        end
        if (rd_pend) begin
            iRdData = ram[rd_paddr];
            rd_pend = 1'b0;
        end else begin
            iRdData = 8'($urandom);
        end
        if (oRdEn) begin
            if (addrq.size() > 0) chk("rd_addr", 32'(oRdAddr), 32'(addrq.pop_front()));
            else                  chk("rd_spurious", 32'(oRdEn), 0);
            rd_pend  = 1'b1;
            rd_paddr = oRdAddr;
        end
    end

    task automatic clr();
        nstrobe = 0; pre_cnt = 0; post_cnt = 0; dir_hits = 0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        @(negedge clk);
        iRxData  = b;
        iRxValid = 1'b1;
        @(negedge clk);
        iRxValid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic req(input logic [7:0] cyc, input logic [7:0] cnt, input logic [7:0] c);
        send(8'hA5, 2); send(cyc, 2); send(cnt, 2); send(c, 2);
    endtask

    task automatic push_resp(input logic [7:0] cyc, input int cnt);
        logic [7:0]  x;
        logic [10:0] a;
        x = 8'h5A ^ {2'b00, cyc[5:0]};
        txq.push_back(8'h5A);
        txq.push_back({2'b00, cyc[5:0]});
        for (int i = 0; i < cnt; i++) begin
            a = {cyc[5:0], 5'b00000} + 11'(i);
            addrq.push_back(a);
            txq.push_back(ram[a]);
            x = x ^ ram[a];
        end
        txq.push_back(x);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while (oBusy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("idle", 32'(oBusy), 0);
        repeat (3) @(negedge clk);
        chk("sb_tx_left", 32'(txq.size()), 0);
        chk("sb_rd_left", 32'(addrq.size()), 0);
        chk("dir_tx_off", 32'(oDirTX), 0);
        chk("dir_rx_off", 32'(oDirRX), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, ns;
        for (int i = 0; i < 2048; i++) ram[i] = 8'($urandom);
        ram[160] = 8'h11; ram[161] = 8'h22; ram[162] = 8'h33;

        repeat (3) @(negedge clk);
        chk("rst_txstart", 32'(oTxStart), 0);
        chk("rst_rden",    32'(oRdEn), 0);
        chk("rst_dirtx",   32'(oDirTX), 0);
        chk("rst_dirrx",   32'(oDirRX), 0);
        chk("rst_busy",    32'(oBusy), 0);
        chk("rst_txdata",  32'(oTxData), 0);
        chk("rst_rdaddr",  32'(oRdAddr), 0);
        chk("rst_errcnt",  32'(oErrCnt), 0);
        rst = 1'b0;

        // Nominal request.
        clr(); push_resp(8'h05, 3);
        req(8'h05, 8'h03, 8'hA3);
        wait_idle();
        chk("s1_nstrobe", 32'(nstrobe), 6);
        chk("s1_pre_guard",  32'(pre_cnt >= GUARD && pre_cnt <= GUARD + 2), 1);
        chk("s1_post_guard", 32'(post_cnt >= GUARD && post_cnt <= GUARD + 2), 1);
        chk("s1_err", 32'(oErrCnt), 0);

        // Bad checksum.
        clr(); req(8'h05, 8'h03, 8'h00); wait_idle();
        chk("s2_nstrobe", 32'(nstrobe), 0);
        chk("s2_dir", 32'(dir_hits), 0);
        chk("s2_err", 32'(oErrCnt), 1);

        // CNT out of range, checksums correct.
        clr(); req(8'h05, 8'h00, 8'hA0); req(8'h05, 8'h21, 8'h81); wait_idle();
        chk("s3_nstrobe", 32'(nstrobe), 0);
        chk("s3_err", 32'(oErrCnt), 3);

        // Inter-byte timeout; trailing bytes land in IDLE and are ignored.
        clr(); send(8'hA5, TIMEOUT); send(8'h05, 2); send(8'h03, 2); send(8'hA3, 2);
        wait_idle();
        chk("s4_nstrobe", 32'(nstrobe), 0);
        chk("s4_err", 32'(oErrCnt), 4);

        // Gap just below the limit is accepted.
        clr(); push_resp(8'h05, 3);
        send(8'hA5, TIMEOUT - 2); send(8'h05, 2); send(8'h03, 2); send(8'hA3, 2);
        wait_idle();
        chk("s5_nstrobe", 32'(nstrobe), 6);
        chk("s5_err", 32'(oErrCnt), 4);

        // Junk in IDLE, then CYC with top bits set (ignored in response).
        clr(); send(8'h00, 2); send(8'h5A, 2); send(8'hFF, 2);
        push_resp(8'hC2, 2);
        req(8'hC2, 8'h02, 8'h65);
        wait_idle();
        chk("s6_nstrobe", 32'(nstrobe), 5);
        chk("s6_err", 32'(oErrCnt), 4);

        // Max CYC/CNT with slow transmitter.
        clr(); tx_len = 50; push_resp(8'h3F, MAXCNT);
        req(8'h3F, 8'h20, 8'hBA);
        wait_idle();
        tx_len = 3;
        chk("s7_nstrobe", 32'(nstrobe), MAXCNT + 3);
        chk("s7_err", 32'(oErrCnt), 4);

        // Error counter saturation.
        clr();
        for (int k = 0; k < 252; k++) begin
            send(8'hA5, 1); send(8'h05, 1); send(8'h03, 1); send(8'h00, 1);
        end
        wait_idle();
        chk("s8_err_sat", 32'(oErrCnt), 8'hFF);
        chk("s8_nstrobe", 32'(nstrobe), 0);

        // Reset during the second data byte.
        clr(); push_resp(8'h05, 3);
        req(8'h05, 8'h03, 8'hA3);
        n = 0;
        while (nstrobe < 4 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("s9_reach_d1", 32'(nstrobe >= 4), 1);
        #2 rst = 1'b1;
        #1;
        chk("s9_txstart", 32'(oTxStart), 0);
        chk("s9_dirtx",   32'(oDirTX), 0);
        chk("s9_dirrx",   32'(oDirRX), 0);
        chk("s9_busy",    32'(oBusy), 0);
        chk("s9_rden",    32'(oRdEn), 0);
        chk("s9_txdata",  32'(oTxData), 0);
        chk("s9_err",     32'(oErrCnt), 0);
        txq.delete(); addrq.delete();
        @(negedge clk);
        rst = 1'b0;
        ns = nstrobe; dir_hits = 0;
        repeat (300) @(negedge clk);
        chk("s9_no_strobe", 32'(nstrobe), 32'(ns));
        chk("s9_no_dir", 32'(dir_hits), 0);

        clr(); push_resp(8'h05, 3);
        req(8'h05, 8'h03, 8'hA3);
        wait_idle();
        chk("s10_nstrobe", 32'(nstrobe), 6);
        chk("s10_err", 32'(oErrCnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
